rggen_bit_field_irq_status: RTL

RGGEN_BIT_FIELD_IRQ_STATUS -- requirements
Module: rggen_bit_field_irq_status

---
 rtl/rggen_bit_field_if.sv | 19 +
 rtl/rggen_bit_field_irq_status.sv | 56 +++++
 2 files changed

// File: rtl/rggen_bit_field_if.sv
// rggen_bit_field_if: register access bundle (valid, read/write masks, write data, read data, value) shared by bit fields
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;
  modport bit_field (
    input  valid,
    input  read_mask,
    input  write_mask,
    input  write_data,
    output read_data,
    output value
  );
endinterface

// File: rtl/rggen_bit_field_irq_status.sv
// rggen_bit_field_irq_status: sticky irq status bits set by i_event (level/edge), cleared by sw (w0c/w1c/rc); outputs o_value, o_value_unmasked, o_overflow, o_irq
module rggen_bit_field_irq_status #(
  parameter int               WIDTH           = 8,
  parameter int               CLEAR_MODE      = 1,
  parameter int               SET_MODE        = 0,
  parameter logic [WIDTH-1:0] INITIAL_VALUE   = '0,
  parameter int               OVERFLOW_ENABLE = 1
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  rggen_bit_field_if.bit_field bit_field_if,
  input  logic [WIDTH-1:0]     i_event,
  input  logic [WIDTH-1:0]     i_enable,
  output logic [WIDTH-1:0]     o_value,
  output logic [WIDTH-1:0]     o_value_unmasked,
  output logic [WIDTH-1:0]     o_overflow,
  output logic                 o_irq
);
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] overflow;
  logic [WIDTH-1:0] ev_q;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] ovf_cond;
  logic             write_access;
  logic             read_access;
  assign write_access = bit_field_if.valid && (bit_field_if.write_mask != '0);
  assign read_access  = bit_field_if.valid && (bit_field_if.write_mask == '0);
  always_comb begin
    detect   = (SET_MODE == 0) ? i_event :
               (SET_MODE == 1) ? i_event & ~ev_q :
               (SET_MODE == 2) ? ~i_event & ev_q : i_event ^ ev_q;
    clear    = (CLEAR_MODE == 2) ? {WIDTH{read_access}} & bit_field_if.read_mask :
               (CLEAR_MODE == 0) ? {WIDTH{write_access}} & bit_field_if.write_mask & ~bit_field_if.write_data :
                                   {WIDTH{write_access}} & bit_field_if.write_mask & bit_field_if.write_data;
    ovf_cond = detect & status & ~clear;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      status   <= INITIAL_VALUE;
      overflow <= '0;
      o_irq    <= 1'b0;
      ev_q     <= i_event;
    end else begin
      status   <= detect | (status & ~clear);
      overflow <= (OVERFLOW_ENABLE != 0) ? ovf_cond | (overflow & ~clear) : '0;
      o_irq    <= |(status & i_enable);
      ev_q     <= i_event;
    end
  end
  assign o_value                = status & i_enable;
  assign o_value_unmasked       = status;
  assign o_overflow             = overflow;
  assign bit_field_if.read_data = status;
  assign bit_field_if.value     = status;
endmodule
